// File: rtl/traffic_light_monitor.sv
// Passive checker for the four 3-bit traffic light buses: safety, sequencing, timing, stall.
// Optional rotation-order check is built when ORDER_CHECK_EN is defined.
module traffic_light_monitor #(
  parameter int unsigned MIN_GREEN     = 4,
  parameter int unsigned YELLOW_CYCLES = 3,
  parameter int unsigned MAX_ALL_RED   = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light_path_left,
  input  logic [2:0]       light_path_right,
  input  logic [2:0]       light_straight,
  input  logic [2:0]       light_back,
  input  logic             clr_err,
  output logic             err_encoding,
  output logic             err_conflict,
  output logic             err_sequence,
  output logic             err_timing,
  output logic             err_stall,
  output logic             err_order,
  output logic             err_any,
  output logic             active_valid,
  output logic [1:0]       active_dir,
  output logic [CNT_W-1:0] phase_cnt,
  output logic [15:0]      cycle_count
);

  localparam logic [2:0] Red    = 3'b100;
  localparam logic [2:0] Yellow = 3'b010;
  localparam logic [2:0] Green  = 3'b001;

  localparam logic [CNT_W-1:0] MinGreen   = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] YellowCnt  = CNT_W'(YELLOW_CYCLES);
  localparam logic [CNT_W-1:0] YellowOver = CNT_W'(YELLOW_CYCLES + 1);
  localparam logic [CNT_W-1:0] StallAt    = CNT_W'(MAX_ALL_RED + 1);

  typedef enum logic [1:0] {
    KindAllRed   = 2'd0,
    KindConflict = 2'd1,
    KindSingle   = 2'd2
  } kind_e;

  // What the crossing is doing this cycle; any change restarts phase_cnt.
  typedef struct packed {
    kind_e      kind;
    logic [1:0] dir;
    logic [2:0] colour;
  } sig_t;

  logic [3:0][2:0] bus;
  logic [3:0][2:0] dec;
  logic [3:0][2:0] prev_q, prev_d;
  logic [3:0]      legal;
  logic [2:0]      n_nonred;
  logic [1:0]      last_nonred;
  sig_t            sig_q, sig_d;
  logic            same_sig;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [1:0]      dir_q, dir_d;
  logic            valid_q, valid_d;
  logic [15:0]     cycles_q;
  logic            cycle_inc;
  logic            v_enc, v_conf, v_seq, v_tim, v_stall;
  logic            err_enc_q, err_conf_q, err_seq_q, err_tim_q, err_stall_q, err_any_q;
  logic            err_enc_d, err_conf_d, err_seq_d, err_tim_d, err_stall_d, err_order_d;

  assign bus = {light_back, light_straight, light_path_right, light_path_left};

  always_comb begin
    n_nonred    = '0;
    last_nonred = '0;
    v_enc       = 1'b0;
    v_seq       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      legal[i]  = (bus[i] == Red) || (bus[i] == Yellow) || (bus[i] == Green);
      dec[i]    = legal[i] ? bus[i] : Red;
      prev_d[i] = legal[i] ? bus[i] : prev_q[i];
      if (!legal[i]) v_enc = 1'b1;
      if (dec[i] != Red) begin
        n_nonred    = n_nonred + 3'd1;
        last_nonred = 2'(i);
      end
      if ((prev_q[i] == Red    && dec[i] == Yellow) ||
          (prev_q[i] == Green  && dec[i] == Red)    ||
          (prev_q[i] == Yellow && dec[i] == Green)) begin
        v_seq = 1'b1;
      end
    end

    v_conf  = n_nonred > 3'd1;
    valid_d = n_nonred == 3'd1;
    dir_d   = valid_d ? last_nonred : dir_q;

    sig_d = '{kind: KindAllRed, dir: 2'd0, colour: 3'd0};
    if (valid_d) begin
      sig_d = '{kind: KindSingle, dir: last_nonred, colour: dec[last_nonred]};
    end else if (v_conf) begin
      sig_d.kind = KindConflict;
    end

    same_sig = sig_d == sig_q;
    if (!same_sig) begin
      phase_d = CNT_W'(1);
    end else if (phase_q == {CNT_W{1'b1}}) begin
      phase_d = phase_q;
    end else begin
      phase_d = phase_q + CNT_W'(1);
    end

    // Transition checks use the count accumulated by the previously active approach.
    v_tim = 1'b0;
    if (sig_q.kind == KindSingle) begin
      if (sig_q.colour == Green && dec[sig_q.dir] == Yellow && phase_q < MinGreen) v_tim = 1'b1;
      if (sig_q.colour == Yellow && dec[sig_q.dir] == Red && phase_q != YellowCnt) v_tim = 1'b1;
      if (same_sig && sig_q.colour == Yellow && phase_d == YellowOver) v_tim = 1'b1;
    end

    v_stall   = (n_nonred == 3'd0) && (phase_d == StallAt);
    cycle_inc = (prev_q[3] == Yellow) && (dec[3] == Red);

    err_enc_d   = (err_enc_q   & ~clr_err) | v_enc;
    err_conf_d  = (err_conf_q  & ~clr_err) | v_conf;
    err_seq_d   = (err_seq_q   & ~clr_err) | v_seq;
    err_tim_d   = (err_tim_q   & ~clr_err) | v_tim;
    err_stall_d = (err_stall_q & ~clr_err) | v_stall;
  end

`ifdef ORDER_CHECK_EN
  logic [1:0] last_green_q, last_green_d;
  logic       last_valid_q, last_valid_d;
  logic       v_ord;
  logic       err_order_q;

  always_comb begin
    last_green_d = last_green_q;
    last_valid_d = last_valid_q;
    v_ord        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (prev_q[i] == Red && dec[i] == Green) begin
        if (last_valid_q && (2'(i) != last_green_q + 2'd1)) v_ord = 1'b1;
        last_green_d = 2'(i);
        last_valid_d = 1'b1;
      end
    end
  end

  assign err_order_d = (err_order_q & ~clr_err) | v_ord;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_green_q <= 2'd0;
      last_valid_q <= 1'b0;
      err_order_q  <= 1'b0;
    end else begin
      last_green_q <= last_green_d;
      last_valid_q <= last_valid_d;
      err_order_q  <= err_order_d;
    end
  end

  assign err_order = err_order_q;
`else
  assign err_order_d = 1'b0;
  assign err_order   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= {4{Red}};
      sig_q       <= '{kind: KindAllRed, dir: 2'd0, colour: 3'd0};
      phase_q     <= '0;
      dir_q       <= 2'd0;
      valid_q     <= 1'b0;
      cycles_q    <= 16'd0;
      err_enc_q   <= 1'b0;
      err_conf_q  <= 1'b0;
      err_seq_q   <= 1'b0;
      err_tim_q   <= 1'b0;
      err_stall_q <= 1'b0;
      err_any_q   <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      sig_q       <= sig_d;
      phase_q     <= phase_d;
      dir_q       <= dir_d;
      valid_q     <= valid_d;
      cycles_q    <= cycles_q + {15'd0, cycle_inc};
      err_enc_q   <= err_enc_d;
      err_conf_q  <= err_conf_d;
      err_seq_q   <= err_seq_d;
      err_tim_q   <= err_tim_d;
      err_stall_q <= err_stall_d;
      err_any_q   <= err_enc_d | err_conf_d | err_seq_d | err_tim_d | err_stall_d | err_order_d;
    end
  end

  assign err_encoding = err_enc_q;
  assign err_conflict = err_conf_q;
  assign err_sequence = err_seq_q;
  assign err_timing   = err_tim_q;
  assign err_stall    = err_stall_q;
  assign err_any      = err_any_q;
  assign active_valid = valid_q;
  assign active_dir   = dir_q;
  assign phase_cnt    = phase_q;
  assign cycle_count  = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized light sequences
// compared every cycle against a colour-index reference model.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam int MinGreen = 4;
  localparam int YellowCycles = 3;
  localparam int MaxAllRed = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_err = 1'b0;
  logic [2:0]  drv [4];
  logic        err_encoding, err_conflict, err_sequence, err_timing, err_stall, err_order;
  logic        err_any, active_valid;
  logic [1:0]  active_dir;
  logic [15:0] phase_cnt, cycle_count;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk              (clk),
    .rst              (rst),
    .light_path_left  (drv[0]),
    .light_path_right (drv[1]),
    .light_straight   (drv[2]),
    .light_back       (drv[3]),
    .clr_err          (clr_err),
    .err_encoding     (err_encoding),
    .err_conflict     (err_conflict),
    .err_sequence     (err_sequence),
    .err_timing       (err_timing),
    .err_stall        (err_stall),
    .err_order        (err_order),
    .err_any          (err_any),
    .active_valid     (active_valid),
    .active_dir       (active_dir),
    .phase_cnt        (phase_cnt),
    .cycle_count      (cycle_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: colours as 0=red 1=yellow 2=green; legal successor of c is (c+2)%3.
  // mode: -1 all red, -2 conflict, else dir*3+colour of the single active approach.
  int          m_prev [4];
  int          m_mode, m_run, m_dir, m_last;
  bit          m_valid, m_last_v;
  bit          m_enc, m_conf, m_seq, m_tim, m_stall, m_ord;
  logic [15:0] m_cyc;
  bit          inject_en = 1'b0;

  function automatic int colour_of(input logic [2:0] c);
    case (c)
      R:       return 0;
      Y:       return 1;
      G:       return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_prev[i] = 0;
    m_mode = -1; m_run = 0; m_dir = 0; m_last = 0;
    m_valid = 0; m_last_v = 0; m_cyc = 16'd0;
    {m_enc, m_conf, m_seq, m_tim, m_stall, m_ord} = '0;
  endtask

  task automatic model_step();
    int col [4];
    int eff [4];
    int nonred, who, mode, run, pd, pc, old_last;
    bit ve, vc, vs, vt, vst, vo, old_v;
    if (rst) begin
      model_reset();
      return;
    end
    nonred = 0; who = 0;
    {ve, vc, vs, vt, vst, vo} = '0;
    for (int i = 0; i < 4; i++) begin
      col[i] = colour_of(drv[i]);
      eff[i] = (col[i] < 0) ? 0 : col[i];
      if (col[i] < 0) ve = 1;
      if (eff[i] != 0) begin nonred++; who = i; end
      if (eff[i] != m_prev[i] && eff[i] != (m_prev[i] + 2) % 3) vs = 1;
    end
    vc   = nonred > 1;
    mode = (nonred == 0) ? -1 : (nonred > 1) ? -2 : who * 3 + eff[who];
    run  = (mode == m_mode) ? ((m_run < 65535) ? m_run + 1 : m_run) : 1;
    if (m_mode >= 0) begin
      pd = m_mode / 3;
      pc = m_mode % 3;
      if (pc == 2 && eff[pd] == 1 && m_run < MinGreen) vt = 1;
      if (pc == 1 && eff[pd] == 0 && m_run != YellowCycles) vt = 1;
      if (mode == m_mode && pc == 1 && run == YellowCycles + 1) vt = 1;
    end
    vst = (mode == -1) && (run == MaxAllRed + 1);
    if (m_prev[3] == 1 && eff[3] == 0) m_cyc = m_cyc + 16'd1;
    old_v = m_last_v; old_last = m_last;
    for (int i = 0; i < 4; i++) begin
      if (m_prev[i] == 0 && eff[i] == 2) begin
        if (old_v && i != (old_last + 1) % 4) vo = 1;
        m_last = i; m_last_v = 1;
      end
    end
    m_valid = nonred == 1;
    if (m_valid) m_dir = who;
    for (int i = 0; i < 4; i++) if (col[i] >= 0) m_prev[i] = col[i];
    m_mode = mode; m_run = run;
    m_enc   = (m_enc   && !clr_err) || ve;
    m_conf  = (m_conf  && !clr_err) || vc;
    m_seq   = (m_seq   && !clr_err) || vs;
    m_tim   = (m_tim   && !clr_err) || vt;
    m_stall = (m_stall && !clr_err) || vst;
    m_ord   = (m_ord   && !clr_err) || vo;
  endtask

  task automatic compare_all();
    bit exp_ord;
`ifdef ORDER_CHECK_EN
    exp_ord = m_ord;
`else
    exp_ord = 1'b0;
`endif
    check_eq("err_encoding", err_encoding, m_enc);
    check_eq("err_conflict", err_conflict, m_conf);
    check_eq("err_sequence", err_sequence, m_seq);
    check_eq("err_timing", err_timing, m_tim);
    check_eq("err_stall", err_stall, m_stall);
    check_eq("err_order", err_order, exp_ord);
    check_eq("err_any", err_any, m_enc | m_conf | m_seq | m_tim | m_stall | exp_ord);
    check_eq("active_valid", active_valid, m_valid);
    check_eq("active_dir", active_dir, m_dir);
    check_eq("phase_cnt", phase_cnt, m_run);
    check_eq("cycle_count", cycle_count, m_cyc);
  endtask

  task automatic step4(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                       input logic [2:0] c3, input logic clr, input logic rs);
    drv[0] = c0; drv[1] = c1; drv[2] = c2; drv[3] = c3;
    clr_err = clr;
    rst = rs;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Hold one approach at a colour for n cycles, others red, with optional random faults.
  task automatic show(input int dir, input logic [2:0] code, input int n);
    logic [2:0] c [4];
    logic clr, rs;
    int r;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) c[i] = R;
      c[dir] = code;
      clr = 1'b0; rs = 1'b0;
      if (inject_en) begin
        r = $urandom_range(0, 99);
        if (r < 3) c[$urandom_range(0, 3)] = 3'($urandom);
        else if (r < 5) c[$urandom_range(0, 3)] = G;
        clr = $urandom_range(0, 29) == 0;
        rs  = $urandom_range(0, 299) == 0;
      end
      step4(c[0], c[1], c[2], c[3], clr, rs);
    end
  endtask

  task automatic do_reset();
    step4(R, R, R, R, 1'b0, 1'b1);
  endtask

  initial begin
    int d;
    model_reset();
    for (int i = 0; i < 4; i++) drv[i] = R;
    do_reset();
    do_reset();
    check_eq("reset_err_any", err_any, 0);
    check_eq("reset_phase", phase_cnt, 0);
    check_eq("reset_cycles", cycle_count, 0);

    // Legal rotation, three times round.
    for (int rot = 0; rot < 3; rot++) begin
      for (int k = 0; k < 4; k++) begin
        show(k, G, 5);
        if (k == 0) check_eq("rot_green_phase", phase_cnt, 5);
        show(k, Y, 3);
        show(k, R, 2);
      end
    end
    check_eq("rot_cycles", cycle_count, 3);
    check_eq("rot_clean", err_any, 0);

    // Encoding, clear without violation, clear coincident with a conflict.
    do_reset();
    step4(R, 3'b011, R, R, 1'b0, 1'b0);
    check_eq("bad_code", err_encoding, 1);
    step4(R, R, R, R, 1'b1, 1'b0);
    check_eq("clr_clears", err_any, 0);
    step4(G, R, G, R, 1'b1, 1'b0);
    check_eq("clr_vs_conflict", err_conflict, 1);
    check_eq("conflict_invalid", active_valid, 0);
    step4(G, R, R, R, 1'b0, 1'b0);
    check_eq("conflict_sticky", err_conflict, 1);

    // Green straight to red.
    do_reset();
    show(0, G, 3);
    show(0, R, 1);
    check_eq("green_to_red", err_sequence, 1);

    // Short green, then overlong yellow.
    do_reset();
    show(0, G, 2);
    show(0, Y, 1);
    check_eq("short_green", err_timing, 1);
    do_reset();
    show(0, G, 5);
    show(0, Y, 3);
    check_eq("yellow_exact", err_timing, 0);
    show(0, Y, 1);
    check_eq("yellow_over", err_timing, 1);

    // Stall boundary.
    do_reset();
    show(0, R, MaxAllRed);
    check_eq("stall_edge", err_stall, 0);
    show(0, R, 1);
    check_eq("stall", err_stall, 1);

    // Reset mid-green.
    do_reset();
    show(0, G, 3);
    step4(G, R, R, R, 1'b0, 1'b1);
    check_eq("mid_reset_valid", active_valid, 0);
    check_eq("mid_reset_phase", phase_cnt, 0);

    // Out-of-order green: left then straight.
    do_reset();
    show(0, G, 5);
    show(0, Y, 3);
    show(0, R, 1);
    show(2, G, 2);
`ifdef ORDER_CHECK_EN
    check_eq("order_skip", err_order, 1);
`else
    check_eq("order_off", err_order, 0);
`endif

    // Randomized rotations with injected faults, clears and resets.
    do_reset();
    inject_en = 1'b1;
    d = 0;
    for (int seg = 0; seg < 60; seg++) begin
      d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : (d + 1) % 4;
      show(d, G, $urandom_range(1, 6));
      show(d, Y, $urandom_range(2, 4));
      if ($urandom_range(0, 9) == 0) show(d, R, $urandom_range(60, 70));
      else show(d, R, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker that sits on the four 3-bit light buses driven by the 4-way traffic light controller and verifies them from the receiving side. It decodes each bus, enforces the safety rules and phase timing, tracks which approach holds right-of-way, and counts completed rotations. It drives no lights. Its sticky error flags go to the top-level status register and to simulation benches as a live assertion block.

## Interface
Parameters:
- MIN_GREEN, 4: minimum consecutive cycles a green must be held before it may turn yellow.
- YELLOW_CYCLES, 3: exact number of consecutive cycles yellow must be held.
- MAX_ALL_RED, 64: maximum consecutive all-red cycles before a stall error.
- CNT_W, 16: width of the phase-duration counter, which saturates.

Ports:
- clk, in, 1: single clock; every register updates on its rising edge.
- rst, in, 1: synchronous reset, active-high.
- light_path_left, in, 3: left approach; red=3'b100, yellow=3'b010, green=3'b001.
- light_path_right, in, 3: right approach; same encoding.
- light_straight, in, 3: straight approach; same encoding.
- light_back, in, 3: back approach; same encoding.
- clr_err, in, 1: clears all sticky error flags.
- err_encoding, out, 1: sticky; a bus carried a value other than the three legal codes.
- err_conflict, out, 1: sticky; more than one approach was non-red at the same time.
- err_sequence, out, 1: sticky; an approach made an illegal colour transition.
- err_timing, out, 1: sticky; green was shorter than MIN_GREEN, or yellow was not exactly YELLOW_CYCLES.
- err_stall, out, 1: sticky; all four approaches were red for more than MAX_ALL_RED cycles.
- err_order, out, 1: sticky; rotation order was violated (only when ORDER_CHECK_EN is defined).
- err_any, out, 1: OR of all error flags.
- active_valid, out, 1: exactly one approach is non-red.
- active_dir, out, 2: approach holding right-of-way; 0=left, 1=right, 2=straight, 3=back.
- phase_cnt, out, CNT_W: cycles elapsed in the current colour of the active approach, or in the current all-red period.
- cycle_count, out, 16: number of completed rotations; wraps modulo 2^16.

## Operation
- Previous-value registers hold one sample per bus and reset to red (3'b100). Every check compares the current input with the previous sample.
- Encoding check: a bus value outside {100, 010, 001} sets err_encoding. That bus is treated as red for all other checks in that cycle, and its previous-value register is not updated.
- Conflict check: two or more decoded non-red buses set err_conflict. In that cycle active_valid is 0 and active_dir holds its last value.
- Legal transitions per approach: hold, red→green, green→yellow, yellow→red. Any other change (red→yellow, green→red, yellow→green) sets err_sequence.
- phase_cnt:
  - Resets to 1 on any colour change of the active approach, and on entry to all-red.
  - Otherwise increments, saturating at 2^CNT_W−1.
  - phase_cnt always counts the cycles spent in the current colour, including the current one.
- Timing checks:
  - On green→yellow, err_timing is set if the green count is below MIN_GREEN.
  - On yellow→red, err_timing is set if the yellow count is not equal to YELLOW_CYCLES.
  - Yellow held beyond YELLOW_CYCLES sets err_timing at cycle YELLOW_CYCLES+1; it is not deferred to the yellow→red transition.
- Stall check: the all-red count exceeding MAX_ALL_RED sets err_stall, once per all-red period.
- cycle_count increments on each yellow→red transition of the back approach.
- Sticky flags:
  - Cleared by rst, or by clr_err.
  - If clr_err and a new violation occur in the same cycle, the violation wins and the flag stays 1.
- Reset mid-operation: all state returns to reset values, and checking restarts. The first green seen after reset is accepted from the reset-red state.

## Timing
- Latency: a violation on the inputs sampled at edge N is visible on the error outputs immediately after edge N. All outputs are registered.
- active_valid, active_dir and phase_cnt reflect the inputs sampled at the same edge.
- Reset values:
  - All err_* outputs are 0.
  - active_valid=0 and active_dir=0.
  - phase_cnt=0 and cycle_count=0.
- Checks stay active through the sticky state: a flag that is already set remains set, and further violations are still evaluated.

## Configuration
- ORDER_CHECK_EN defined:
  - The required green order is left→right→straight→back→left.
  - A last-green register (2 bits, plus a valid bit that resets to 0) records the most recent green approach.
  - Any red→green on an approach other than last+1 (mod 4) sets err_order.
  - The first green after reset is accepted for any approach.
- ORDER_CHECK_EN undefined: no order-tracking logic is built, and err_order is tied to 0.

## Test plan
- Legal rotation: left, right, straight and back in turn, each green 5 cycles, yellow 3 cycles, red gap 2 cycles, run for 3 rotations → all err_* stay 0; cycle_count=3; phase_cnt reaches 5 during each green.
- Conflict: left and straight both at 3'b001 for one cycle → err_conflict=1 after that edge; active_valid=0; err_conflict stays 1 until clr_err is pulsed.
- Bad encoding and sequence: right=3'b011 for one cycle → err_encoding=1. Separately, left going 3'b001→3'b100 → err_sequence=1.
- Timing: green held 2 cycles then yellow → err_timing=1 at the yellow edge. Yellow held 4 cycles → err_timing=1 after the 4th yellow cycle.
- Stall, clear and reset: all-red for 65 cycles → err_stall=1. clr_err pulsed with no violation → all flags 0. clr_err coincident with a conflict → err_conflict=1. rst pulsed mid-green → every output returns to its reset value at the next edge.
- ORDER_CHECK_EN: sequence left→straight → err_order=1. The same sequence without the macro → err_order=0.
